redirect_ctrl: RTL and testbench

REDIRECT_CTRL -- requirements
Module: redirect_ctrl

---
 rtl/redirect_ctrl.sv | 98 +++++++++
 tb/tb_redirect_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/redirect_ctrl.sv
// Redirect controller: turns resolved branches and trap requests into a
// registered fetch redirect with pipeline flush/stall control and an accept counter.
module redirect_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic             trap_req,
    input  logic [31:0]      trap_target,
    input  logic             redirect_ready,
    output logic             redirect_valid,
    output logic [31:0]      redirect_addr,
    output logic             flush_if,
    output logic             flush_id,
    output logic             stall_ex,
    output logic             misalign,
    output logic [CNT_W-1:0] redirect_count
);

    typedef enum logic {IDLE, REDIRECT} state_t;

    state_t             state, state_nx;
    logic               valid_nx;
    logic [31:0]        addr_nx;
    logic               flush_nx;
    logic               mis_nx;
    logic [CNT_W-1:0]   cnt_nx;
    logic               br_take;
    logic               br_aligned;
    logic               handshake;

    assign br_take    = br_valid && br_taken;
    assign br_aligned = (br_target[1:0] == 2'b00);
    assign handshake  = redirect_valid && redirect_ready;

    always_comb begin
        state_nx = state;
        addr_nx  = redirect_addr;
        flush_nx = 1'b0;
        mis_nx   = 1'b0;
        cnt_nx   = redirect_count;
        case (state)
            IDLE: begin
                // A misaligned target still reports even when a trap wins the cycle.
                mis_nx = br_take && !br_aligned;
                if (trap_req) begin
                    addr_nx  = trap_target;
                    flush_nx = 1'b1;
                    state_nx = REDIRECT;
                end else if (br_take && br_aligned) begin
                    addr_nx  = br_target;
                    flush_nx = 1'b1;
                    state_nx = REDIRECT;
                end
            end
            REDIRECT: begin
                if (handshake) begin
                    cnt_nx = redirect_count + CNT_W'(1);
                    if (!trap_req)
                        state_nx = IDLE;
                end
                // Trap retargets the pending redirect regardless of acceptance.
                if (trap_req) begin
                    addr_nx  = trap_target;
                    flush_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        valid_nx = (state_nx == REDIRECT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
            redirect_addr  <= 32'h0;
            flush_if       <= 1'b0;
            flush_id       <= 1'b0;
            stall_ex       <= 1'b0;
            misalign       <= 1'b0;
            redirect_count <= '0;
        end else begin
            state          <= state_nx;
            redirect_valid <= valid_nx;
            redirect_addr  <= addr_nx;
            flush_if       <= flush_nx;
            flush_id       <= flush_nx;
            stall_ex       <= valid_nx;
            misalign       <= mis_nx;
            redirect_count <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_redirect_ctrl.sv
// Vector table plus hand-built wrap sequence; expectations flow through a scoreboard queue.
module tb_redirect_ctrl;
    localparam int CNT_W = 4;
    localparam int OW    = 37 + CNT_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             br_valid, br_taken, trap_req, redirect_ready;
    logic [31:0]      br_target, trap_target;
    logic             redirect_valid, flush_if, flush_id, stall_ex, misalign;
    logic [31:0]      redirect_addr;
    logic [CNT_W-1:0] redirect_count;

    redirect_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
        .trap_req(trap_req), .trap_target(trap_target),
        .redirect_ready(redirect_ready),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .flush_if(flush_if), .flush_id(flush_id), .stall_ex(stall_ex),
        .misalign(misalign), .redirect_count(redirect_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             rst, bv, bt, tr, rdy;
        logic [31:0]      btgt, ttgt;
        logic             e_valid, e_flush, e_stall, e_mis;
        logic [31:0]      e_addr;
        logic [CNT_W-1:0] e_cnt;
    } vec_t;

    vec_t          vecs[$];
    logic [OW-1:0] sb[$];
    int            n_pass = 0, n_total = 0;

    function automatic vec_t mk(input logic r, bv, bt, input logic [31:0] bg,
                                input logic tr, input logic [31:0] tg, input logic rdy,
                                input logic ev, input logic [31:0] ea, input logic ef,
                                input logic es, input logic em, input int ec);
        vec_t v;
        v.rst = r; v.bv = bv; v.bt = bt; v.btgt = bg; v.tr = tr; v.ttgt = tg; v.rdy = rdy;
        v.e_valid = ev; v.e_addr = ea; v.e_flush = ef; v.e_stall = es; v.e_mis = em;
        v.e_cnt = CNT_W'(ec);
        return v;
    endfunction

    task automatic step(input vec_t v, input string name);
        logic [OW-1:0] exp_o, act_o;
        @(negedge clk);
        rst = v.rst; br_valid = v.bv; br_taken = v.bt; br_target = v.btgt;
        trap_req = v.tr; trap_target = v.ttgt; redirect_ready = v.rdy;
        sb.push_back({v.e_valid, v.e_addr, v.e_flush, v.e_flush, v.e_stall, v.e_mis, v.e_cnt});
        @(posedge clk);
        #1;
        act_o = {redirect_valid, redirect_addr, flush_if, flush_id, stall_ex, misalign, redirect_count};
        exp_o = sb.pop_front();
        n_total++;
        if (act_o === exp_o) n_pass++;
        else $display("FAIL %s: got v=%b a=%h fi=%b fd=%b st=%b mis=%b cnt=%0d, want v=%b a=%h fi=%b fd=%b st=%b mis=%b cnt=%0d",
                      name, act_o[OW-1], act_o[OW-2 -: 32], act_o[CNT_W+3], act_o[CNT_W+2],
                      act_o[CNT_W+1], act_o[CNT_W], act_o[CNT_W-1:0],
                      exp_o[OW-1], exp_o[OW-2 -: 32], exp_o[CNT_W+3], exp_o[CNT_W+2],
                      exp_o[CNT_W+1], exp_o[CNT_W], exp_o[CNT_W-1:0]);
    endtask

    initial begin
        rst = 1'b1; br_valid = 0; br_taken = 0; br_target = 0;
        trap_req = 0; trap_target = 0; redirect_ready = 0;

        //             rst bv bt btgt          tr ttgt          rdy  v  addr          fl st ms cnt
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0,  0, 32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 32'h1000,     1, 32'h9999_0000,1,  0, 32'h0,        0, 0, 0, 0));
        // single-cycle accept
        vecs.push_back(mk(0, 1, 1, 32'h1000,     0, 32'h0,        1,  1, 32'h1000,     1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1,  0, 32'h1000,     0, 0, 0, 1));
        // held for four cycles; branch inputs ignored while redirecting
        vecs.push_back(mk(0, 1, 1, 32'h2000,     0, 32'h0,        0,  1, 32'h2000,     1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h2000,     0, 1, 0, 1));
        vecs.push_back(mk(0, 1, 1, 32'h1002,     0, 32'h0,        0,  1, 32'h2000,     0, 1, 0, 1));
        vecs.push_back(mk(0, 1, 1, 32'h5000,     0, 32'h0,        0,  1, 32'h2000,     0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1,  0, 32'h2000,     0, 0, 0, 2));
        // trap beats branch in the same cycle
        vecs.push_back(mk(0, 1, 1, 32'h3000,     1, 32'h8000_0000,0,  1, 32'h8000_0000,1, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1,  0, 32'h8000_0000,0, 0, 0, 3));
        // misaligned branch, not-taken branch
        vecs.push_back(mk(0, 1, 1, 32'h1002,     0, 32'h0,        1,  0, 32'h8000_0000,0, 0, 1, 3));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1,  0, 32'h8000_0000,0, 0, 0, 3));
        vecs.push_back(mk(0, 1, 0, 32'h5000,     0, 32'h0,        1,  0, 32'h8000_0000,0, 0, 0, 3));
        // misaligned branch with coincident trap
        vecs.push_back(mk(0, 1, 1, 32'h1003,     1, 32'h9000,     0,  1, 32'h9000,     1, 1, 1, 3));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1,  0, 32'h9000,     0, 0, 0, 4));
        // trap override while stalled
        vecs.push_back(mk(0, 1, 1, 32'h4000,     0, 32'h0,        0,  1, 32'h4000,     1, 1, 0, 4));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h4000,     0, 1, 0, 4));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h8000_0100,0,  1, 32'h8000_0100,1, 1, 0, 4));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h8000_0100,0, 1, 0, 4));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1,  0, 32'h8000_0100,0, 0, 0, 5));
        // trap override coincident with handshake
        vecs.push_back(mk(0, 1, 1, 32'h6000,     0, 32'h0,        0,  1, 32'h6000,     1, 1, 0, 5));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hA000,     1,  1, 32'hA000,     1, 1, 0, 6));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1,  0, 32'hA000,     0, 0, 0, 7));
        // reset mid-redirect drops it
        vecs.push_back(mk(0, 1, 1, 32'h7000,     0, 32'h0,        0,  1, 32'h7000,     1, 1, 0, 7));
        vecs.push_back(mk(1, 1, 1, 32'h7100,     1, 32'hB000,     1,  0, 32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1,  0, 32'h0,        0, 0, 0, 0));

        foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

        // counter wrap: repeated trap overrides accepted every cycle
        step(mk(0, 0, 0, 32'h0, 1, 32'hC000, 0, 1, 32'hC000, 1, 1, 0, 0), "wrap_enter");
        for (int k = 1; k < (1 << CNT_W); k++)
            step(mk(0, 0, 0, 32'h0, 1, 32'hC000 + 32'(k * 4), 1,
                    1, 32'hC000 + 32'(k * 4), 1, 1, 0, k), $sformatf("wrap_fill%0d", k));
        step(mk(0, 0, 0, 32'h0, 0, 32'h0, 1, 0, 32'hC000 + 32'(((1 << CNT_W) - 1) * 4), 0, 0, 0, 0),
             "wrap_zero");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion, want summary");
        $fatal(1, "timeout");
    end
endmodule
